// File: rtl/multicycle_ctrl_if.sv
// Handshake and control bundle between the multi-cycle controller (master)
// and the datapath / memory side (slave).
interface multicycle_ctrl_if #(
   parameter int unsigned CNT_W = 32
);
   logic             run;
   logic [5:0]       op;
   logic [5:0]       func;
   logic             zero;
   logic             imem_ack;
   logic             dmem_ack;
   logic             imem_req;
   logic             dmem_req;
   logic             dmem_we;
   logic             ir_write;
   logic             pc_write;
   logic [1:0]       pc_sel;
   logic             reg_write;
   logic             reg_dst;
   logic             mem_to_reg;
   logic             busy;
   logic             trap;
   logic [1:0]       trap_code;
   logic [CNT_W-1:0] instr_count;

   modport master (
      input  run, op, func, zero, imem_ack, dmem_ack,
      output imem_req, dmem_req, dmem_we, ir_write, pc_write, pc_sel,
             reg_write, reg_dst, mem_to_reg, busy, trap, trap_code, instr_count
   );

   modport slave (
      output run, op, func, zero, imem_ack, dmem_ack,
      input  imem_req, dmem_req, dmem_we, ir_write, pc_write, pc_sel,
             reg_write, reg_dst, mem_to_reg, busy, trap, trap_code, instr_count
   );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multi-cycle control FSM (IF/ID/EX/MEM/WB) with imem/dmem req/ack handshakes,
// a per-request watchdog, a retired-instruction counter and a sticky trap.
module multicycle_ctrl #(
   parameter int unsigned TIMEOUT = 16,
   parameter int unsigned CNT_W   = 32
) (
   input  logic clk,
   input  logic rst_n,
   multicycle_ctrl_if.master bus
);
   localparam int unsigned WAIT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_IF, S_ID, S_EX, S_MEM, S_WB, S_TRAP
   } state_e;

   state_e            state_q, state_d;
   logic [WAIT_W-1:0] wait_q, wait_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [1:0]        code_q, code_d;

   logic is_r, is_jr, is_ialu, is_lw, is_sw, is_beq, is_j;
   logic imem_req, dmem_req, dmem_we, ir_write, pc_write;
   logic reg_write, reg_dst, mem_to_reg, retire;
   logic [1:0] pc_sel;

   assign is_r    = (bus.op == 6'h00) && (bus.func != 6'h08);
   assign is_jr   = (bus.op == 6'h00) && (bus.func == 6'h08);
   assign is_ialu = (bus.op == 6'h08) || (bus.op == 6'h0C) ||
                    (bus.op == 6'h0D) || (bus.op == 6'h0F);
   assign is_lw   = (bus.op == 6'h23);
   assign is_sw   = (bus.op == 6'h2B);
   assign is_beq  = (bus.op == 6'h04);
   assign is_j    = (bus.op == 6'h02);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         wait_q  <= '0;
         cnt_q   <= '0;
         code_q  <= '0;
      end else begin
         state_q <= state_d;
         wait_q  <= wait_d;
         cnt_q   <= cnt_d;
         code_q  <= code_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      wait_d     = wait_q;
      cnt_d      = cnt_q;
      code_d     = code_q;
      imem_req   = 1'b0;
      dmem_req   = 1'b0;
      dmem_we    = 1'b0;
      ir_write   = 1'b0;
      pc_write   = 1'b0;
      pc_sel     = 2'b00;
      reg_write  = 1'b0;
      reg_dst    = 1'b0;
      mem_to_reg = 1'b0;
      retire     = 1'b0;
      unique case (state_q)
         S_IDLE: if (bus.run) state_d = S_IF;
         S_IF: begin
            imem_req = 1'b1;
            if (bus.imem_ack) begin
               ir_write = 1'b1;
               pc_write = 1'b1;
               state_d  = S_ID;
            end else if (wait_q == WAIT_LAST) begin
               state_d = S_TRAP;
               code_d  = 2'b10;
            end
         end
         S_ID: state_d = S_EX;
         S_EX: begin
            if (is_beq) begin
               pc_sel   = 2'b01;
               pc_write = bus.zero;
               retire   = 1'b1;
            end else if (is_jr) begin
               pc_sel   = 2'b10;
               pc_write = 1'b1;
               retire   = 1'b1;
            end else if (is_j) begin
               pc_sel   = 2'b11;
               pc_write = 1'b1;
               retire   = 1'b1;
            end else if (is_lw || is_sw) begin
               state_d = S_MEM;
            end else if (is_r || is_ialu) begin
               state_d = S_WB;
            end else begin
               state_d = S_TRAP;
               code_d  = 2'b01;
            end
         end
         S_MEM: begin
            dmem_req = 1'b1;
            dmem_we  = is_sw;
            if (bus.dmem_ack) begin
               if (is_sw) retire  = 1'b1;
               else       state_d = S_WB;
            end else if (wait_q == WAIT_LAST) begin
               state_d = S_TRAP;
               code_d  = 2'b11;
            end
         end
         S_WB: begin
            reg_write  = 1'b1;
            reg_dst    = is_r;
            mem_to_reg = is_lw;
            retire     = 1'b1;
         end
         S_TRAP: state_d = S_TRAP;
         default: state_d = S_IDLE;
      endcase

      // run is only looked at here, at the instruction boundary
      if (retire) begin
         cnt_d   = cnt_q + CNT_W'(1);
         state_d = bus.run ? S_IF : S_IDLE;
      end

      // Any state change is an entry into IF/MEM or leaves the wait entirely
      if (state_d != state_q)
         wait_d = '0;
      else if ((imem_req && !bus.imem_ack) || (dmem_req && !bus.dmem_ack))
         wait_d = wait_q + WAIT_W'(1);
   end

   assign bus.imem_req    = imem_req;
   assign bus.dmem_req    = dmem_req;
   assign bus.dmem_we     = dmem_we;
   assign bus.ir_write    = ir_write;
   assign bus.pc_write    = pc_write;
   assign bus.pc_sel      = pc_sel;
   assign bus.reg_write   = reg_write;
   assign bus.reg_dst     = reg_dst;
   assign bus.mem_to_reg  = mem_to_reg;
   assign bus.busy        = (state_q != S_IDLE) && (state_q != S_TRAP);
   assign bus.trap        = (state_q == S_TRAP);
   assign bus.trap_code   = code_q;
   assign bus.instr_count = cnt_q;
endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: a reset/R-type vector table, directed
// corner cases, and random instruction streams against a per-instruction trace model.
module tb_multicycle_ctrl;
   localparam int unsigned TO = 16;
   localparam int C_R = 0, C_JR = 1, C_IALU = 2, C_LW = 3, C_SW = 4, C_BEQ = 5, C_J = 6, C_ILL = 7;

   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic rst_n  = 1'b0;
   logic rst2_n = 1'b0;

   multicycle_ctrl_if #(.CNT_W(32)) bus ();
   multicycle_ctrl_if #(.CNT_W(4))  bus2 ();

   multicycle_ctrl #(.TIMEOUT(TO), .CNT_W(32)) dut  (.clk(clk), .rst_n(rst_n),  .bus(bus));
   multicycle_ctrl #(.TIMEOUT(2),  .CNT_W(4))  dut2 (.clk(clk), .rst_n(rst2_n), .bus(bus2));

   typedef struct {
      logic        run;
      logic [5:0]  op;
      logic [5:0]  fn;
      logic        z;
      logic        ia;
      logic        da;
      logic [13:0] exp;
      logic [31:0] cnt;
   } step_t;

   step_t       q[$];
   step_t       tbl[6];
   logic [5:0]  legal[9];
   logic [31:0] mcnt;
   bit          idle;
   int          checks = 0;
   int          errors = 0;
   int          sidx   = 0;

   // {imem_req,dmem_req,dmem_we,ir_write,pc_write,pc_sel,reg_write,reg_dst,mem_to_reg,busy,trap,trap_code}
   function automatic logic [13:0] o(input int ireq, dreq, we, irw, pcw, sel,
                                     input int rw, rd, m2r, bsy, trp, code);
      return {1'(ireq), 1'(dreq), 1'(we), 1'(irw), 1'(pcw), 2'(sel),
              1'(rw), 1'(rd), 1'(m2r), 1'(bsy), 1'(trp), 2'(code)};
   endfunction

   function automatic logic [13:0] act();
      return {bus.imem_req, bus.dmem_req, bus.dmem_we, bus.ir_write, bus.pc_write,
              bus.pc_sel, bus.reg_write, bus.reg_dst, bus.mem_to_reg, bus.busy,
              bus.trap, bus.trap_code};
   endfunction

   function automatic int classify(input logic [5:0] op, fn);
      case (op)
         6'h00:                      return (fn == 6'h08) ? C_JR : C_R;
         6'h08, 6'h0C, 6'h0D, 6'h0F: return C_IALU;
         6'h23:                      return C_LW;
         6'h2B:                      return C_SW;
         6'h04:                      return C_BEQ;
         6'h02:                      return C_J;
         default:                    return C_ILL;
      endcase
   endfunction

   function automatic logic nz(input bit noise);
      return noise ? 1'($urandom) : 1'b0;
   endfunction

   function automatic logic mr(input bit noise, input logic run_mid);
      return noise ? 1'($urandom) : run_mid;
   endfunction

   task automatic apply(input step_t s, input string name);
      bus.run = s.run; bus.op = s.op; bus.func = s.fn; bus.zero = s.z;
      bus.imem_ack = s.ia; bus.dmem_ack = s.da;
      @(negedge clk);
      checks++;
      if ({act(), bus.instr_count} !== {s.exp, s.cnt}) begin
         errors++;
         $display("FAIL %s: out=%h cnt=%0d, expected out=%h cnt=%0d",
                  name, act(), bus.instr_count, s.exp, s.cnt);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic drain(input string name);
      while (q.size() > 0) begin
         apply(q.pop_front(), $sformatf("%s[%0d]", name, sidx));
         sidx++;
      end
   endtask

   task automatic push(input logic run, input logic [5:0] op, fn, input logic z, ia, da,
                       input logic [13:0] exp);
      step_t s;
      s.run = run; s.op = op; s.fn = fn; s.z = z; s.ia = ia; s.da = da;
      s.exp = exp; s.cnt = mcnt;
      q.push_back(s);
   endtask

   task automatic retire(input logic run, input logic [5:0] op, fn, input logic z, ia, da,
                         input logic [13:0] exp);
      push(run, op, fn, z, ia, da, exp);
      mcnt++;
      if (!run) begin
         push(1'b0, op, fn, z, 1'b0, 1'b0, 14'h0);
         idle = 1'b1;
      end
   endtask

   // Expected cycle trace of one instruction, starting in IF (or IDLE if idle).
   task automatic push_instr(input logic [5:0] op, fn, input logic z,
                             input int unsigned di, dd,
                             input logic run_mid, run_ret, input bit noise);
      int          cls;
      logic [1:0]  tcode;
      logic [13:0] bsy;
      cls   = classify(op, fn);
      tcode = 2'b00;
      bsy   = o(0,0,0,0,0,0, 0,0,0,1,0,0);
      if (idle) begin
         push(1'b1, op, fn, z, nz(noise), nz(noise), 14'h0);
         idle = 1'b0;
      end
      for (int unsigned k = 0; k < di && k < TO; k++)
         push(mr(noise, run_mid), op, fn, z, 1'b0, nz(noise), o(1,0,0,0,0,0, 0,0,0,1,0,0));
      if (di >= TO) tcode = 2'b10;
      else begin
         push(mr(noise, run_mid), op, fn, z, 1'b1, nz(noise), o(1,0,0,1,1,0, 0,0,0,1,0,0));
         push(mr(noise, run_mid), op, fn, z, nz(noise), nz(noise), bsy);
         if (cls == C_BEQ)
            retire(run_ret, op, fn, z, nz(noise), nz(noise), o(0,0,0,0,int'(z),1, 0,0,0,1,0,0));
         else if (cls == C_JR)
            retire(run_ret, op, fn, z, nz(noise), nz(noise), o(0,0,0,0,1,2, 0,0,0,1,0,0));
         else if (cls == C_J)
            retire(run_ret, op, fn, z, nz(noise), nz(noise), o(0,0,0,0,1,3, 0,0,0,1,0,0));
         else if (cls == C_ILL) begin
            push(mr(noise, run_mid), op, fn, z, nz(noise), nz(noise), bsy);
            tcode = 2'b01;
         end else begin
            push(mr(noise, run_mid), op, fn, z, nz(noise), nz(noise), bsy);
            if (cls == C_LW || cls == C_SW) begin
               for (int unsigned k = 0; k < dd && k < TO; k++)
                  push(mr(noise, run_mid), op, fn, z, nz(noise), 1'b0,
                       o(0,1,int'(cls == C_SW),0,0,0, 0,0,0,1,0,0));
               if (dd >= TO) tcode = 2'b11;
               else if (cls == C_SW)
                  retire(run_ret, op, fn, z, nz(noise), 1'b1, o(0,1,1,0,0,0, 0,0,0,1,0,0));
               else
                  push(mr(noise, run_mid), op, fn, z, nz(noise), 1'b1, o(0,1,0,0,0,0, 0,0,0,1,0,0));
            end
            if (tcode == 2'b00 && cls != C_SW)
               retire(run_ret, op, fn, z, nz(noise), nz(noise),
                      o(0,0,0,0,0,0, 1,int'(cls == C_R),int'(cls == C_LW),1,0,0));
         end
      end
      if (tcode != 2'b00)
         for (int t = 0; t < 3; t++)
            push(1'b1, op, fn, z, 1'b1, 1'b1, o(0,0,0,0,0,0, 0,0,0,0,1,int'(tcode)));
   endtask

   task automatic do_reset();
      step_t s;
      rst_n = 1'b0;
      mcnt  = '0;
      idle  = 1'b1;
      q.delete();
      s = '{1'b1, 6'h00, 6'h20, 1'b1, 1'b1, 1'b1, 14'h0, 32'h0};
      apply(s, "reset");
      rst_n = 1'b1;
   endtask

   initial begin
      int unsigned n, di, dd;
      logic [3:0]  exp4;
      tbl[0] = '{1'b1, 6'h00, 6'h20, 1'b0, 1'b0, 1'b0, o(0,0,0,0,0,0, 0,0,0,0,0,0), 32'd0};
      tbl[1] = '{1'b1, 6'h00, 6'h20, 1'b0, 1'b1, 1'b0, o(1,0,0,1,1,0, 0,0,0,1,0,0), 32'd0};
      tbl[2] = '{1'b1, 6'h00, 6'h20, 1'b0, 1'b0, 1'b0, o(0,0,0,0,0,0, 0,0,0,1,0,0), 32'd0};
      tbl[3] = '{1'b1, 6'h00, 6'h20, 1'b0, 1'b0, 1'b0, o(0,0,0,0,0,0, 0,0,0,1,0,0), 32'd0};
      tbl[4] = '{1'b1, 6'h00, 6'h20, 1'b0, 1'b0, 1'b0, o(0,0,0,0,0,0, 1,1,0,1,0,0), 32'd0};
      tbl[5] = '{1'b1, 6'h00, 6'h20, 1'b0, 1'b0, 1'b0, o(1,0,0,0,0,0, 0,0,0,1,0,0), 32'd1};
      legal  = '{6'h00, 6'h08, 6'h0C, 6'h0D, 6'h0F, 6'h23, 6'h2B, 6'h04, 6'h02};
      bus2.run = 1'b1; bus2.op = 6'h00; bus2.func = 6'h20; bus2.zero = 1'b0;
      bus2.imem_ack = 1'b1; bus2.dmem_ack = 1'b1;

      do_reset();
      for (int i = 0; i < 6; i++) apply(tbl[i], $sformatf("rtype_tbl[%0d]", i));

      do_reset();
      push_instr(6'h23, 6'h00, 1'b0, 0, 3,  1'b1, 1'b1, 1'b0);
      push_instr(6'h04, 6'h00, 1'b1, 0, 0,  1'b1, 1'b1, 1'b0);
      push_instr(6'h04, 6'h00, 1'b0, 0, 0,  1'b1, 1'b1, 1'b0);
      push_instr(6'h00, 6'h08, 1'b0, 0, 0,  1'b1, 1'b1, 1'b0);
      push_instr(6'h02, 6'h00, 1'b0, 1, 0,  1'b1, 1'b1, 1'b0);
      push_instr(6'h0D, 6'h00, 1'b0, 0, 0,  1'b1, 1'b1, 1'b0);
      push_instr(6'h2B, 6'h00, 1'b0, 0, 2,  1'b1, 1'b0, 1'b0);
      drain("directed");

      for (int i = 0; i < 60; i++) begin
         logic [5:0] op, fn;
         op = legal[$urandom_range(0, 8)];
         fn = ($urandom_range(0, 3) == 0) ? 6'h08 : 6'($urandom);
         di = ($urandom_range(0, 9) == 0) ? TO - 1 : $urandom_range(0, 3);
         dd = ($urandom_range(0, 9) == 0) ? TO - 1 : $urandom_range(0, 3);
         push_instr(op, fn, 1'($urandom), di, dd, 1'b1, 1'($urandom_range(0, 4) != 0), 1'b1);
         drain("rand");
      end

      // Reset asserted mid-MEM of a LW: dmem_req must drop without a clock edge
      n = (idle ? 1 : 0) + 5;
      push_instr(6'h23, 6'h00, 1'b0, 0, 10, 1'b1, 1'b1, 1'b0);
      for (int unsigned i = 0; i < n; i++) apply(q.pop_front(), $sformatf("pre_rst[%0d]", i));
      q.delete();
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if ({bus.dmem_req, bus.busy, bus.instr_count} !== 34'h0) begin
         errors++;
         $display("FAIL async_rst: dmem_req=%b busy=%b cnt=%0d, expected 0 0 0",
                  bus.dmem_req, bus.busy, bus.instr_count);
      end

      do_reset();
      push_instr(6'h00, 6'h20, 1'b0, TO, 0, 1'b1, 1'b1, 1'b0);
      drain("imem_timeout");

      do_reset();
      push_instr(6'h00, 6'h20, 1'b0, TO - 1, 0,      1'b1, 1'b1, 1'b0);
      push_instr(6'h23, 6'h00, 1'b0, 0,      TO - 1, 1'b1, 1'b1, 1'b0);
      push_instr(6'h2B, 6'h00, 1'b0, 0,      TO,     1'b1, 1'b1, 1'b0);
      drain("edge_ack_then_dmem_timeout");

      do_reset();
      push_instr(6'h00, 6'h20, 1'b0, 0, 0, 1'b1, 1'b1, 1'b0);
      push_instr(6'h3F, 6'h00, 1'b0, 0, 0, 1'b1, 1'b1, 1'b0);
      drain("illegal");

      do_reset();
      push_instr(6'h00, 6'h25, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0);
      push(1'b0, 6'h00, 6'h25, 1'b0, 1'b1, 1'b1, 14'h0);
      drain("run_drop");

      @(posedge clk);
      #1 rst2_n = 1'b1;
      for (int e = 1; e <= 69; e++) begin
         @(posedge clk);
         if (e == 61 || e == 65 || e == 69) begin
            @(negedge clk);
            exp4 = 4'((e - 1) / 4);
            checks++;
            if (bus2.instr_count !== exp4) begin
               errors++;
               $display("FAIL wrap_e%0d: cnt=%0d, expected %0d", e, bus2.instr_count, exp4);
            end
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
